control_unit_mc: RTL and testbench
==================================

// Module: control_unit_mc
// PURPOSE
//  Multicycle control FSM for the 64-bit RISC-V datapath. Takes the opcode/funct3
//  decoded from the datapath IR plus the ALU flags, and sequences fetch, decode,
//  execute, memory and write-back. It drives every datapath control strobe, including
//  the IR/PC load enables. It also counts retired instructions and traps unsupported
//  encodings.
// PARAMETERS
//  MEM_WAIT  1   cycles spent in MEM state (data-memory latency), legal 1..15
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  run        in   1      1: fetch next instruction; 0: park in FETCH without strobes
//  opcode     in   7      IR[6:0] from datapath
//  funct3     in   3      IR[14:12] from datapath
//  alu_flags  in   4      {equal, overflow, msb, zero} from datapath ALU
//  ir_we      out  1      load IR from i_mem_data
//  pc_we      out  1      load PC with next-PC
//  pc_src     out  1      0: PC+4, 1: PC+imm
//  alu_cmd    out  4      0000 R, 0001 I, 0010 S, 0011 SB, 0100 U, 0101 UJ
//  alu_src    out  1      0: register B, 1: immediate
//  rf_src     out  1      0: ALU result, 1: data memory
//  rf_we      out  1      register-file write enable
//  d_mem_we   out  1      data-memory write enable
//  illegal    out  1      sticky: unsupported instruction trapped
//  state      out  3      current FSM state (debug)
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, class=NONE, wait counter=0, instret=0,
//   illegal=0; all strobes 0, alu_cmd=0000, pc_src/alu_src/rf_src=0.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Moore outputs come from
//   state + class register.
//  FETCH:
//   - run=0: stay, all strobes 0.
//   - run=1: ir_we=1, go to DECODE.
//  DECODE: opcode is valid here. Latch class into a register; opcode changes
//   after DECODE are ignored. Go to EXEC, or to TRAP if the class is unsupported.
//  Classes:
//   - R 0110011
//   - I 0010011
//   - LD 0000011
//   - ST 0100011
//   - BR 1100011 (funct3 000 BEQ, 001 BNE only)
//   - LUI 0110111
//   - JAL 1101111
//   Any other opcode, or BR with another funct3 -> TRAP.
//  alu_cmd/alu_src are held constant from EXEC through WB. By class:
//   - R: 0000/0
//   - I, LD: 0001/1
//   - ST: 0010/1
//   - BR: 0011/0
//   - LUI: 0100/1
//   - JAL: 0101/1
//  EXEC transitions:
//   - R, I, LUI -> WB.
//   - LD, ST -> MEM.
//   - BR: pc_we=1, pc_src = taken (BEQ: alu_flags[3]; BNE: !alu_flags[3]); retire
//     -> FETCH.
//   - JAL: pc_we=1, pc_src=1, no link write (rd must be x0); retire -> FETCH.
//  MEM: stays MEM_WAIT cycles, counted by the wait counter, which is cleared on entry.
//   - LD: after the wait -> WB.
//   - ST: d_mem_we=1 on the last MEM cycle only, together with pc_we=1 and pc_src=0;
//     retire -> FETCH.
//  WB: rf_we=1, pc_we=1, pc_src=0. rf_src=1 for LD, 0 otherwise. Retire -> FETCH.
//  Retire: instret+=1 on the cycle the final pc_we is asserted. Wraps
//   2^CNT_W-1 -> 0 silently.
//  TRAP: illegal=1, all strobes 0, PC not advanced. Only rst_n exits TRAP; run is
//   ignored there.
//  rf_we and d_mem_we are never both 1. Each is a single-cycle pulse per instruction.
//  Reset mid-instruction: all strobes drop immediately (async). No partial write is
//   re-issued.
//  run is sampled only in FETCH. Deasserting it mid-instruction does not stall the
//   instruction in flight.
// TESTING
//  1. R add (opcode 0110011): state 0,1,2,4,0; rf_we=1 only in WB; pc_we/pc_src=1/0;
//     instret 0->1.
//  2. LD with MEM_WAIT=3: 0,1,2,3,3,3,4; in WB rf_src=1 and rf_we=1; d_mem_we stays
//     0 throughout.
//  3. ST: d_mem_we=1 for exactly one cycle (last MEM cycle); rf_we never 1;
//     alu_cmd=0010, alu_src=1.
//  4. BEQ with flags[3]=1 -> pc_src=1. BNE with flags[3]=1 -> pc_src=0. Branch
//     funct3=100 -> TRAP with illegal=1.
//  5. opcode 1110011 -> TRAP; 10 further cycles with run=1 keep illegal=1 and all
//     strobes 0; rst_n pulse returns to FETCH.
//  6. run=0 after reset: FETCH held 20 cycles, no strobes. Assert rst_n low during
//     WB: rf_we drops the same cycle. Preload instret=2^CNT_W-1 (force), retire one
//     instruction -> instret=0.

Source files
------------

// File: rtl/control_unit_mc.sv
// Multicycle control FSM for the 64-bit RISC-V datapath: sequences fetch, decode,
// execute, memory and write-back, counts retired instructions and traps unsupported encodings.
module control_unit_mc #(
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [3:0]       alu_flags,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic [3:0]       alu_cmd,
   output logic             alu_src,
   output logic             rf_src,
   output logic             rf_we,
   output logic             d_mem_we,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      C_NONE = 4'd0,
      C_R    = 4'd1,
      C_I    = 4'd2,
      C_LD   = 4'd3,
      C_ST   = 4'd4,
      C_BEQ  = 4'd5,
      C_BNE  = 4'd6,
      C_LUI  = 4'd7,
      C_JAL  = 4'd8
   } class_e;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

   state_e           state_q, state_d;
   class_e           class_q, class_d;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             illegal_q, illegal_d;
   logic             mem_last_s;
   logic             unused_flags_s;

   function automatic class_e decode_class(input logic [6:0] op, input logic [2:0] f3);
      class_e c;
      case (op)
         7'b0110011: c = C_R;
         7'b0010011: c = C_I;
         7'b0000011: c = C_LD;
         7'b0100011: c = C_ST;
         7'b1100011: begin
            if (f3 == 3'b000) begin
               c = C_BEQ;
            end else if (f3 == 3'b001) begin
               c = C_BNE;
            end else begin
               c = C_NONE;
            end
         end
         7'b0110111: c = C_LUI;
         7'b1101111: c = C_JAL;
         default:    c = C_NONE;
      endcase
      return c;
   endfunction

   // {alu_cmd, alu_src} for a latched class
   function automatic logic [4:0] alu_ctrl(input class_e c);
      logic [4:0] v;
      case (c)
         C_R:          v = {4'b0000, 1'b0};
         C_I, C_LD:    v = {4'b0001, 1'b1};
         C_ST:         v = {4'b0010, 1'b1};
         C_BEQ, C_BNE: v = {4'b0011, 1'b0};
         C_LUI:        v = {4'b0100, 1'b1};
         C_JAL:        v = {4'b0101, 1'b1};
         default:      v = 5'b00000;
      endcase
      return v;
   endfunction

   assign mem_last_s     = (wait_q == WAIT_LAST);
   assign unused_flags_s = ^alu_flags[2:0];
   assign state          = state_q;
   assign instret        = instret_q;
   assign illegal        = illegal_q;

   // State, class, wait counter, retire counter and sticky trap flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         class_q   <= C_NONE;
         wait_q    <= 4'd0;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (run) begin
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            class_d = decode_class(opcode, funct3);
            if (class_d == C_NONE) begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (class_q)
               C_R, C_I, C_LUI:      state_d = S_WB;
               C_LD, C_ST: begin
                  state_d = S_MEM;
                  wait_d  = 4'd0;
               end
               C_BEQ, C_BNE, C_JAL: state_d = S_FETCH;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (!mem_last_s) begin
               wait_d = wait_q + 4'd1;
            end else if (class_q == C_LD) begin
               state_d = S_WB;
            end else if (class_q == C_ST) begin
               state_d = S_FETCH;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
         end
      endcase
   end

   // Datapath strobes from state and latched class; fetch strobe is gated by reset
   always_comb begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      alu_cmd  = 4'b0000;
      alu_src  = 1'b0;
      rf_src   = 1'b0;
      rf_we    = 1'b0;
      d_mem_we = 1'b0;
      case (state_q)
         S_FETCH: ir_we = run & rst_n;
         S_EXEC: begin
            {alu_cmd, alu_src} = alu_ctrl(class_q);
            if (class_q == C_BEQ) begin
               pc_we  = 1'b1;
               pc_src = alu_flags[3];
            end else if (class_q == C_BNE) begin
               pc_we  = 1'b1;
               pc_src = ~alu_flags[3];
            end else if (class_q == C_JAL) begin
               pc_we  = 1'b1;
               pc_src = 1'b1;
            end else begin
               pc_we  = 1'b0;
            end
         end
         S_MEM: begin
            {alu_cmd, alu_src} = alu_ctrl(class_q);
            if ((class_q == C_ST) && mem_last_s) begin
               d_mem_we = 1'b1;
               pc_we    = 1'b1;
            end else begin
               d_mem_we = 1'b0;
            end
         end
         S_WB: begin
            {alu_cmd, alu_src} = alu_ctrl(class_q);
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            rf_src = (class_q == C_LD);
         end
         default: ir_we = 1'b0;
      endcase
   end

   // An instruction retires on its final PC update
   always_comb begin
      if (pc_we) begin
         instret_d = instret_q + CNT_W'(1);
      end else begin
         instret_d = instret_q;
      end
   end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed self-checking bench for control_unit_mc (MEM_WAIT=3, CNT_W=32).
module tb_control_unit_mc;

   localparam int unsigned MEM_WAIT = 3;
   localparam int unsigned CNT_W    = 32;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   logic             clk, rst_n, run;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [3:0]       alu_flags;
   logic             ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, illegal;
   logic [3:0]       alu_cmd;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   int checks   = 0;
   int failures = 0;
   logic [CNT_W-1:0] exp_instret = '0;

   // per-cycle capture; strobe vector = {ir_we, pc_we, pc_src, rf_we, rf_src, d_mem_we}
   logic [2:0] obs_state [0:15];
   logic [5:0] obs_strb  [0:15];
   logic [4:0] obs_alu   [0:15];
   logic       obs_ill   [0:15];

   control_unit_mc #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
      .alu_flags(alu_flags), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_cmd(alu_cmd), .alu_src(alu_src), .rf_src(rf_src), .rf_we(rf_we),
      .d_mem_we(d_mem_we), .illegal(illegal), .state(state), .instret(instret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Launch one instruction from FETCH and record n cycles; opcode is scrambled after DECODE
   task automatic run_cap(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl, input int n);
      run = 1'b1; opcode = op; funct3 = f3; alu_flags = fl;
      for (int i = 0; i < n; i++) begin
         #1;
         obs_state[i] = state;
         obs_strb[i]  = {ir_we, pc_we, pc_src, rf_we, rf_src, d_mem_we};
         obs_alu[i]   = {alu_cmd, alu_src};
         obs_ill[i]   = illegal;
         @(posedge clk); #1;
         if (i == 0) run = 1'b0;
         if (i == 1) opcode = 7'b1111111;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; run = 1'b1; opcode = OP_R; funct3 = 3'b000; alu_flags = 4'b0000;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({state, ir_we, pc_we, pc_src, rf_we, rf_src, d_mem_we, alu_cmd, alu_src, illegal} !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs got state=%0d ir_we=%b pc_we=%b alu_cmd=%b illegal=%b exp all zero",
                  state, ir_we, pc_we, alu_cmd, illegal);
      end
      checks++;
      if (instret !== '0) begin
         failures++;
         $display("FAIL reset_instret got=%0d exp=0", instret);
      end
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_park();
      run = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({state, ir_we, pc_we, rf_we, d_mem_we} !== 7'd0) begin
            failures++;
            $display("FAIL park[%0d] got state=%0d ir_we=%b pc_we=%b rf_we=%b d_mem_we=%b exp FETCH no strobes",
                     i, state, ir_we, pc_we, rf_we, d_mem_we);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_r_add();
      logic [2:0] es [5];
      logic [5:0] eb [5];
      es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
      eb = '{6'b100000, 6'b000000, 6'b000000, 6'b010100, 6'b000000};
      run_cap(OP_R, 3'b000, 4'b0000, 5);
      exp_instret = exp_instret + 1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs_state[i] !== es[i] || obs_strb[i] !== eb[i]) begin
            failures++;
            $display("FAIL r_add[%0d] got state=%0d strb=%b exp state=%0d strb=%b", i, obs_state[i], obs_strb[i], es[i], eb[i]);
         end
      end
      checks++;
      if (obs_alu[2] !== 5'b00000 || obs_alu[3] !== 5'b00000) begin
         failures++;
         $display("FAIL r_alu got exec=%b wb=%b exp 00000", obs_alu[2], obs_alu[3]);
      end
      checks++;
      if (instret !== exp_instret) begin
         failures++;
         $display("FAIL r_instret got=%0d exp=%0d", instret, exp_instret);
      end
   endtask

   task automatic test_load();
      logic [2:0] es [8];
      logic [5:0] eb [8];
      es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
      eb = '{6'b100000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b010110, 6'b0};
      run_cap(OP_LD, 3'b011, 4'b0000, 8);
      exp_instret = exp_instret + 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs_state[i] !== es[i] || obs_strb[i] !== eb[i]) begin
            failures++;
            $display("FAIL load[%0d] got state=%0d strb=%b exp state=%0d strb=%b", i, obs_state[i], obs_strb[i], es[i], eb[i]);
         end
      end
      checks++;
      if (obs_alu[2] !== 5'b00011 || obs_alu[6] !== 5'b00011 || instret !== exp_instret) begin
         failures++;
         $display("FAIL load_alu_instret got alu=%b/%b instret=%0d exp alu=00011 instret=%0d",
                  obs_alu[2], obs_alu[6], instret, exp_instret);
      end
   endtask

   task automatic test_store();
      logic [2:0] es [7];
      logic [5:0] eb [7];
      es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
      eb = '{6'b100000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b010001, 6'b0};
      run_cap(OP_ST, 3'b011, 4'b0000, 7);
      exp_instret = exp_instret + 1;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (obs_state[i] !== es[i] || obs_strb[i] !== eb[i]) begin
            failures++;
            $display("FAIL store[%0d] got state=%0d strb=%b exp state=%0d strb=%b", i, obs_state[i], obs_strb[i], es[i], eb[i]);
         end
      end
      checks++;
      if (obs_alu[2] !== 5'b00101 || obs_alu[5] !== 5'b00101 || instret !== exp_instret) begin
         failures++;
         $display("FAIL store_alu_instret got alu=%b/%b instret=%0d exp alu=00101 instret=%0d",
                  obs_alu[2], obs_alu[5], instret, exp_instret);
      end
   endtask

   task automatic test_branch_jal();
      logic [6:0] ops [5];
      logic [2:0] f3s [5];
      logic [3:0] fls [5];
      logic [5:0] ebx [5];
      logic [4:0] eal [5];
      ops = '{OP_BR, OP_BR, OP_BR, OP_BR, OP_JAL};
      f3s = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
      fls = '{4'b1000, 4'b0111, 4'b1000, 4'b0000, 4'b0000};
      ebx = '{6'b011000, 6'b010000, 6'b010000, 6'b011000, 6'b011000};
      eal = '{5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b01011};
      for (int k = 0; k < 5; k++) begin
         run_cap(ops[k], f3s[k], fls[k], 4);
         exp_instret = exp_instret + 1;
         checks++;
         if (obs_state[2] !== 3'd2 || obs_strb[2] !== ebx[k] || obs_alu[2] !== eal[k] || obs_state[3] !== 3'd0) begin
            failures++;
            $display("FAIL branch[%0d] got state=%0d strb=%b alu=%b next=%0d exp state=2 strb=%b alu=%b next=0",
                     k, obs_state[2], obs_strb[2], obs_alu[2], obs_state[3], ebx[k], eal[k]);
         end
         checks++;
         if (instret !== exp_instret) begin
            failures++;
            $display("FAIL branch_instret[%0d] got=%0d exp=%0d", k, instret, exp_instret);
         end
      end
   endtask

   task automatic test_i_lui();
      logic [6:0] ops [2];
      logic [4:0] eal [2];
      ops = '{OP_I, OP_LUI};
      eal = '{5'b00011, 5'b01001};
      for (int k = 0; k < 2; k++) begin
         run_cap(ops[k], 3'b000, 4'b0000, 5);
         exp_instret = exp_instret + 1;
         checks++;
         if (obs_state[3] !== 3'd4 || obs_strb[3] !== 6'b010100 || obs_alu[2] !== eal[k] || obs_alu[3] !== eal[k]
             || instret !== exp_instret) begin
            failures++;
            $display("FAIL i_lui[%0d] got state=%0d strb=%b alu=%b instret=%0d exp state=4 strb=010100 alu=%b instret=%0d",
                     k, obs_state[3], obs_strb[3], obs_alu[3], instret, eal[k], exp_instret);
         end
      end
   endtask

   task automatic test_reset_mid_wb();
      run = 1'b1; opcode = OP_R; funct3 = 3'b000;
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd4 || rf_we !== 1'b1 || instret !== exp_instret) begin
         failures++;
         $display("FAIL midwb_pre got state=%0d rf_we=%b instret=%0d exp state=4 rf_we=1 instret=%0d",
                  state, rf_we, instret, exp_instret);
      end
      rst_n = 1'b0;
      #1;
      exp_instret = '0;
      checks++;
      if (rf_we !== 1'b0 || pc_we !== 1'b0 || state !== 3'd0 || instret !== exp_instret) begin
         failures++;
         $display("FAIL midwb_reset got rf_we=%b pc_we=%b state=%0d instret=%0d exp 0 0 0 0", rf_we, pc_we, state, instret);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (rf_we !== 1'b0 || state !== 3'd0 || instret !== exp_instret) begin
         failures++;
         $display("FAIL midwb_after got rf_we=%b state=%0d instret=%0d exp 0 0 0", rf_we, state, instret);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      run = 1'b0;
      force dut.instret_q = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.instret_q;
      @(negedge clk); #1;
      checks++;
      if (instret !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL wrap_preload got=%h exp=ffffffff", instret);
      end
      @(negedge clk);
      run_cap(OP_R, 3'b000, 4'b0000, 5);
      exp_instret = '0;
      checks++;
      if (instret !== exp_instret) begin
         failures++;
         $display("FAIL wrap got=%h exp=00000000", instret);
      end
   endtask

   task automatic test_trap(input logic [6:0] op, input logic [2:0] f3, input int extra);
      logic [2:0] es [4];
      logic       ei [4];
      es = '{3'd0, 3'd1, 3'd7, 3'd7};
      ei = '{1'b0, 1'b0, 1'b1, 1'b1};
      run_cap(op, f3, 4'b1000, 4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_state[i] !== es[i] || obs_ill[i] !== ei[i] || (i > 0 && obs_strb[i] !== 6'b0)) begin
            failures++;
            $display("FAIL trap_%b[%0d] got state=%0d illegal=%b strb=%b exp state=%0d illegal=%b",
                     op, i, obs_state[i], obs_ill[i], obs_strb[i], es[i], ei[i]);
         end
      end
      run = 1'b1;
      for (int i = 0; i < extra; i++) begin
         @(negedge clk); #1;
         checks++;
         if (state !== 3'd7 || illegal !== 1'b1 || {ir_we, pc_we, rf_we, d_mem_we} !== 4'b0000) begin
            failures++;
            $display("FAIL trap_hold[%0d] got state=%0d illegal=%b ir_we=%b pc_we=%b exp 7 1 0 0", i, state, illegal, ir_we, pc_we);
         end
      end
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_instret = '0;
      checks++;
      if (state !== 3'd0 || illegal !== 1'b0 || instret !== exp_instret) begin
         failures++;
         $display("FAIL trap_exit got state=%0d illegal=%b instret=%0d exp 0 0 0", state, illegal, instret);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_park();
      test_r_add();
      test_load();
      test_store();
      test_branch_jal();
      test_i_lui();
      test_reset_mid_wb();
      test_wrap();
      test_trap(OP_BR, 3'b100, 0);
      test_trap(OP_SYS, 3'b000, 10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
